// File: rtl/matrix_pkg.sv
// Shared types and sizing for the matrix multiplier datapath and its operand loader.
package matrix_pkg;

   localparam int SEQ_BITS = 14;
   localparam int MAT_N    = SEQ_BITS + 1;
   localparam int MAT_W    = 32;

   typedef logic [MAT_W-1:0] mat_elem_t;
   typedef mat_elem_t mat_t [MAT_N][MAT_N];

   typedef enum logic [2:0] {
      LOAD_A,
      LOAD_B,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } loader_state_e;

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major (row, col) index counter; col advances first and both wrap to 0 after (N-1, N-1).
module matrix_index_counter
   import matrix_pkg::*;
#(
   parameter int N = MAT_N
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc,
   input  logic                 clr,
   output logic [$clog2(N)-1:0] row,
   output logic [$clog2(N)-1:0] col,
   output logic                 last
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   assign last = (row == LAST_IDX) && (col == LAST_IDX);

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         row <= '0;
         col <= '0;
      end else if (inc) begin
         if (col == LAST_IDX) begin
            col <= '0;
            row <= (row == LAST_IDX) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/matrix_operand_loader.sv
// Streams 2*N*N words into operands A and B, starts the multiplier and waits for its done handshake.
// Define MATRIX_LOADER_TRANSPOSE_B_EN to treat the B stream as column-major.
module matrix_operand_loader
   import matrix_pkg::*;
#(
   parameter int N = MAT_N,
   parameter int W = MAT_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [W-1:0]  in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [W-1:0]  matrixA_out [N][N],
   output logic [W-1:0]  matrixB_out [N][N],
   output logic          mult_enable,
   input  logic          mult_done,
   output logic          busy,
   output logic [15:0]   frame_count
);

   localparam int IW = $clog2(N);

   loader_state_e state;
   logic [IW-1:0] row;
   logic [IW-1:0] col;
   logic          last;
   logic          accept;
   logic          idx_clr;

   assign accept  = in_valid && in_ready;
   assign idx_clr = (state == WAIT_DONE) && mult_done;

   matrix_index_counter #(.N(N)) u_index (
      .clk   (clk),
      .reset (reset),
      .inc   (accept),
      .clr   (idx_clr),
      .row   (row),
      .col   (col),
      .last  (last)
   );

   // Outputs are registered; each transition sets the values for the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= LOAD_A;
         in_ready    <= 1'b0;
         mult_enable <= 1'b0;
         busy        <= 1'b0;
         frame_count <= '0;
      end else begin
         mult_enable <= 1'b0;
         case (state)
            LOAD_A: begin
               in_ready <= 1'b1;
               if (accept) begin
                  busy <= 1'b1;
                  if (last) state <= LOAD_B;
               end
            end
            LOAD_B: begin
               if (accept && last) begin
                  state       <= START;
                  in_ready    <= 1'b0;
                  mult_enable <= 1'b1;
               end
            end
            START: state <= WAIT_BUSY;
            // done may still read high from the previous idle period; wait for it to drop first
            WAIT_BUSY: if (!mult_done) state <= WAIT_DONE;
            WAIT_DONE: begin
               if (mult_done) begin
                  state       <= LOAD_A;
                  in_ready    <= 1'b1;
                  busy        <= 1'b0;
                  frame_count <= frame_count + 16'd1;
               end
            end
            default: state <= LOAD_A;
         endcase
      end
   end

   // NOTE: the operands are visible outputs that must read zero after reset, so this storage is reset rather than left as RAM.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               matrixA_out[r][c] <= '0;
               matrixB_out[r][c] <= '0;
            end
         end
      end else if (accept) begin
         if (state == LOAD_A) begin
            matrixA_out[row][col] <= in_data;
         end else if (state == LOAD_B) begin
`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
            matrixB_out[col][row] <= in_data;
`else
            matrixB_out[row][col] <= in_data;
`endif
         end
      end
   end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed self-checking bench for matrix_operand_loader: load latency, backpressure, done handshake, mid-load reset.
module tb_matrix_operand_loader;
   import matrix_pkg::*;

   localparam int N  = MAT_N;
   localparam int W  = MAT_W;
   localparam int NN = N * N;

`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
   localparam logic [31:0] EXP_B23 = 32'd47;
   localparam logic [31:0] EXP_B31 = 32'd18;
`else
   localparam logic [31:0] EXP_B23 = 32'd33;
   localparam logic [31:0] EXP_B31 = 32'd46;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a_mat [N][N];
   logic [W-1:0] b_mat [N][N];
   logic         mult_enable;
   logic         mult_done = 1'b1;
   logic         busy;
   logic [15:0]  frame_count;

   matrix_operand_loader #(.N(N), .W(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .matrixA_out (a_mat),
      .matrixB_out (b_mat),
      .mult_enable (mult_enable),
      .mult_done   (mult_done),
      .busy        (busy),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int en_count = 0;
   int en_cyc   = -1;
   always @(negedge clk) begin
      if (mult_enable) begin
         en_count = en_count + 1;
         en_cyc   = cyc;
      end
   end

   int passes = 0;
   int total  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   logic [W-1:0] src   [2*NN];
   logic [W-1:0] exp_a [N][N];
   logic [W-1:0] exp_b [N][N];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // kind 0: A = identity, B word k = k.  kind 1: A word k = 1000+k, B word k = 3000+k.
   task automatic build_frame(input int kind);
      for (int k = 0; k < NN; k++) begin
         if (kind == 0) begin
            src[k]      = (k / N == k % N) ? 32'd1 : 32'd0;
            src[NN + k] = 32'(k);
         end else begin
            src[k]      = 32'(1000 + k);
            src[NN + k] = 32'(3000 + k);
         end
         exp_a[k / N][k % N] = src[k];
`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
         exp_b[k % N][k / N] = src[NN + k];
`else
         exp_b[k / N][k % N] = src[NN + k];
`endif
      end
   endtask

   function automatic int arr_errs();
      int e = 0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            if (a_mat[r][c] !== exp_a[r][c]) e++;
            if (b_mat[r][c] !== exp_b[r][c]) e++;
         end
      return e;
   endfunction

   function automatic int zero_errs();
      int e = 0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            if (a_mat[r][c] !== '0) e++;
            if (b_mat[r][c] !== '0) e++;
         end
      return e;
   endfunction

   // Presents src[0..nwords-1]; returns the cycle in which word 0 was accepted.
   task automatic load_frame(input int nwords, input bit gaps, output int t_first);
      t_first = -1;
      for (int k = 0; k < nwords; k++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) step();
         end
         in_valid = 1'b1;
         in_data  = src[k];
         for (int w = 0; w < 20 && !in_ready; w++) step();
         if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            break;
         end
         if (k == 0) t_first = cyc;
         step();
      end
      in_valid = 1'b0;
   endtask

   // Call in the START cycle; checks the enable pulse count and its latency from the first accept.
   task automatic post_load(input string tag, input int t_first, input int en_before);
      @(negedge clk);
      #1;
      check({tag, "_en_pulses"}, 32'(en_count - en_before), 32'd1);
      check({tag, "_en_latency"}, 32'(en_cyc - t_first), 32'(2 * NN));
      check({tag, "_arrays"}, 32'(arr_errs()), 32'd0);
   endtask

   task automatic handshake(input int hi, input int lo, input bit junk, input logic [15:0] fc_before);
      int bad = 0;
      repeat (hi) begin
         step();
         if (in_ready || frame_count !== fc_before) bad++;
      end
      mult_done = 1'b0;
      if (junk) begin
         in_valid = 1'b1;
         in_data  = 32'hDEADBEEF;
      end
      repeat (lo) begin
         step();
         if (in_ready || frame_count !== fc_before) bad++;
      end
      check("hs_ready_low_fc_hold", 32'(bad), 32'd0);
      if (junk) check("hs_arrays_stable", 32'(arr_errs()), 32'd0);
      mult_done = 1'b1;
      step();
      in_valid = 1'b0;
      check("hs_fc_inc", 32'(frame_count), 32'(fc_before + 16'd1));
      check("hs_ready_back", 32'(in_ready), 32'd1);
      check("hs_busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t;
      int en0;

      // Reset state
      repeat (3) step();
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fc", 32'(frame_count), 32'd0);
      check("rst_enable", 32'(mult_enable), 32'd0);
      check("rst_arrays_zero", 32'(zero_errs()), 32'd0);
      reset = 1'b0;
      step();
      check("ready_after_reset", 32'(in_ready), 32'd1);

      // Identity frame, continuous valid
      build_frame(0);
      en0 = en_count;
      load_frame(2 * NN, 1'b0, t);
      check("id_ready_start", 32'(in_ready), 32'd0);
      check("id_busy_start", 32'(busy), 32'd1);
      post_load("id", t, en0);
      check("id_a44", a_mat[4][4], 32'd1);
      check("id_a43", a_mat[4][3], 32'd0);
      check("id_b23", b_mat[2][3], EXP_B23);
      check("id_b31", b_mat[3][1], EXP_B31);

      // done held high 3 cycles, low 20, with ignored junk input while waiting
      handshake(3, 20, 1'b1, 16'd0);
      check("hs_enable_once", 32'(en_count - en0), 32'd1);

      // Backpressure frame with new data; first word must land at A[0][0]
      build_frame(1);
      en0 = en_count;
      load_frame(2 * NN, 1'b1, t);
      @(negedge clk);
      #1;
      check("bp_en_pulses", 32'(en_count - en0), 32'd1);
      check("bp_arrays", 32'(arr_errs()), 32'd0);
      check("bp_a00_first_word", a_mat[0][0], 32'd1000);
      handshake(1, 5, 1'b0, 16'd1);

      // Reset after word 100 of A
      build_frame(1);
      en0 = en_count;
      load_frame(100, 1'b0, t);
      check("mid_a69", a_mat[6][9], 32'd1099);
      check("mid_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      step();
      check("mid_rst_ready", 32'(in_ready), 32'd0);
      check("mid_rst_zero", 32'(zero_errs()), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_fc", 32'(frame_count), 32'd0);
      reset = 1'b0;
      step();
      check("mid_no_enable", 32'(en_count - en0), 32'd0);
      build_frame(0);
      load_frame(2 * NN, 1'b0, t);
      post_load("mid", t, en0);
      handshake(2, 4, 1'b0, 16'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
